ram_fifo_ctrl: RTL and testbench

RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

---
 rtl/fifo_pkg.sv | 23 ++
 rtl/fifo_obuf2.sv | 74 +++++++
 rtl/ram_fifo_ctrl.sv | 94 +++++++++
 tb/tb_ram_fifo_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the RAM-backed FIFO controller.
// Holds the default widths, the pointer width and the output-buffer occupancy arithmetic.
package fifo_pkg;

   localparam int DW_DEF    = 8;
   localparam int AW_DEF    = 8;
   localparam int DEPTH_DEF = 256;
   localparam int PTR_W_DEF = AW_DEF + 1;

   typedef enum logic [1:0] {
      OB_EMPTY = 2'd0,
      OB_ONE   = 2'd1,
      OB_TWO   = 2'd2
   } obuf_lvl_e;

   // Slots the output buffer will still hold after this cycle's pop, counting a read in flight.
   function automatic logic [2:0] obuf_next_load(input logic [1:0] obuf_cnt,
                                                 input logic       inflight,
                                                 input logic       pop);
      return {1'b0, obuf_cnt} + {2'b00, inflight} - {2'b00, pop};
   endfunction

endpackage

// File: rtl/fifo_obuf2.sv
// Two-entry output buffer that decouples the one-cycle RAM read latency from downstream.
// The head register drives the downstream data directly, so the output is registered.
module fifo_obuf2
   import fifo_pkg::*;
#(
   parameter int DW = DW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] head,
   output logic [1:0]    cnt,
   output logic          valid
);

   logic [DW-1:0] tail;
   logic [1:0]    cnt_next;
   logic          pop_eff;

   assign pop_eff = pop && valid;

   // Next occupancy from this cycle's capture and removal.
   always_comb begin
      cnt_next = cnt;
      case ({push, pop_eff})
         2'b10:   cnt_next = cnt + 2'd1;
         2'b01:   cnt_next = cnt - 2'd1;
         default: cnt_next = cnt;
      endcase
   end

   // Head/tail storage, occupancy and the registered valid flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         cnt   <= OB_EMPTY;
         valid <= 1'b0;
      end else begin
         cnt   <= cnt_next;
         valid <= (cnt_next != 2'd0);
         case ({push, pop_eff})
            2'b10: begin
               if (cnt == OB_EMPTY) begin
                  head <= din;
               end else begin
                  tail <= din;
               end
            end
            2'b01: begin
               if (cnt == OB_TWO) begin
                  head <= tail;
               end else begin
                  head <= head;
               end
            end
            2'b11: begin
               if (cnt == OB_TWO) begin
                  head <= tail;
                  tail <= din;
               end else begin
                  head <= din;
               end
            end
            default: begin
               head <= head;
            end
         endcase
      end
   end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller driving an external dual-port RAM: port A writes, port B reads.
// Reads are prefetched into a two-entry output buffer to hide the RAM read latency.
module ram_fifo_ctrl
   import fifo_pkg::*;
#(
   parameter int DW    = DW_DEF,
   parameter int AW    = AW_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic [DW-1:0] s_data,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [DW-1:0] m_data,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty,
   output logic          ram_we_a,
   output logic [AW-1:0] ram_addr_a,
   output logic [DW-1:0] ram_din_a,
   output logic          ram_we_b,
   output logic [AW-1:0] ram_addr_b,
   input  logic [DW-1:0] ram_dout_b
);

   localparam int PW = AW + 1;

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] ram_cnt;
   logic          inflight;
   logic [1:0]    obuf_cnt;
   logic          obuf_valid;
   logic          push;
   logic          pop;
   logic          rd_issue;

   // Pointers carry one extra bit so a completely full RAM is distinct from empty.
   assign ram_cnt = wr_ptr - rd_ptr;
   assign full    = (ram_cnt == PW'(DEPTH));
   assign s_ready = !full && !rst;
   assign push    = s_valid && s_ready;
   assign pop     = obuf_valid && m_ready;
   assign m_valid = obuf_valid;

   assign rd_issue = (ram_cnt != '0) && (obuf_next_load(obuf_cnt, inflight, pop) < 3'd2);

   assign ram_we_a   = push;
   assign ram_addr_a = wr_ptr[AW-1:0];
   assign ram_din_a  = s_data;
   assign ram_we_b   = 1'b0;
   assign ram_addr_b = rd_ptr[AW-1:0];

   assign count = ram_cnt + PW'(inflight) + PW'(obuf_cnt);
   assign empty = (count == '0);

   // Write/read pointers and the read-in-flight marker.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         inflight <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end else begin
            wr_ptr <= wr_ptr;
         end
         if (rd_issue) begin
            rd_ptr <= rd_ptr + PW'(1);
         end else begin
            rd_ptr <= rd_ptr;
         end
         inflight <= rd_issue;
      end
   end

   fifo_obuf2 #(
      .DW (DW)
   ) u_obuf (
      .clk   (clk),
      .rst   (rst),
      .push  (inflight),
      .pop   (pop),
      .din   (ram_dout_b),
      .head  (m_data),
      .cnt   (obuf_cnt),
      .valid (obuf_valid)
   );

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Scoreboard bench for ram_fifo_ctrl with a behavioural one-cycle-latency dual-port RAM.
module tb_ram_fifo_ctrl;

   localparam int DW    = 8;
   localparam int AW    = 8;
   localparam int DEPTH = 256;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [DW-1:0] s_data = 8'h00;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic [DW-1:0] m_data;
   logic [AW:0]   count;
   logic          full;
   logic          empty;
   logic          ram_we_a;
   logic [AW-1:0] ram_addr_a;
   logic [DW-1:0] ram_din_a;
   logic          ram_we_b;
   logic [AW-1:0] ram_addr_b;
   logic [DW-1:0] ram_dout_b = 8'h00;

   logic [DW-1:0] mem [0:DEPTH-1];

   int            n_checks = 0;
   int            n_fail   = 0;
   int            pop_cnt  = 0;
   logic [DW-1:0] exp_q [$];

   always #5 clk = ~clk;

   ram_fifo_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_data     (s_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .count      (count),
      .full       (full),
      .empty      (empty),
      .ram_we_a   (ram_we_a),
      .ram_addr_a (ram_addr_a),
      .ram_din_a  (ram_din_a),
      .ram_we_b   (ram_we_b),
      .ram_addr_b (ram_addr_b),
      .ram_dout_b (ram_dout_b)
   );

   always @(posedge clk) begin
      if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
      ram_dout_b <= mem[ram_addr_b];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input int bound);
      int k = 0;
      while (!m_valid && k < bound) begin
         tick();
         k++;
      end
      check("wait_m_valid", 32'(m_valid), 32'd1);
   endtask

   task automatic drain(input int bound);
      int k = 0;
      m_ready = 1'b1;
      while (!empty && k < bound) begin
         tick();
         k++;
      end
      m_ready = 1'b0;
      check("drain_empty", 32'(empty), 32'd1);
   endtask

   // Monitor: mid-cycle, compare occupancy and popped data against the scoreboard queue.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         check("rst_m_valid", 32'(m_valid), 32'd0);
         check("rst_count", 32'(count), 32'd0);
         check("rst_s_ready", 32'(s_ready), 32'd0);
      end else begin
         check("count", 32'(count), 32'(exp_q.size()));
         check("empty", 32'(empty), 32'(exp_q.size() == 0));
         check("ram_we_b", 32'(ram_we_b), 32'd0);
         check("rw_conflict", 32'(dut.rd_issue && ram_we_a && (ram_addr_a == ram_addr_b)), 32'd0);
         if (m_valid && m_ready) begin
            pop_cnt++;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL pop_unexpected: got 0x%0h expected no word", m_data);
            end else begin
               check("m_data", 32'(m_data), 32'(exp_q.pop_front()));
            end
         end
         if (s_valid && s_ready) exp_q.push_back(s_data);
      end
   end

   initial begin
      int bubbles;
      int seen;
      int pop_start;

      // Reset values, with s_valid offered during reset.
      s_valid = 1'b1;
      s_data  = 8'h55;
      repeat (3) tick();
      check("rst_we_a", 32'(ram_we_a), 32'd0);
      check("rst_full", 32'(full), 32'd0);
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_m_data", 32'(m_data), 32'd0);
      s_valid = 1'b0;
      tick();
      rst = 1'b0;
      tick();

      // First-word latency: push 0xA1 in cycle 0, valid in cycle 3.
      s_valid = 1'b1;
      s_data  = 8'hA1;
      #1;
      check("push_we_a", 32'(ram_we_a), 32'd1);
      check("push_addr_a", 32'(ram_addr_a), 32'd0);
      check("push_din_a", 32'(ram_din_a), 32'hA1);
      tick();
      s_valid = 1'b0;
      check("lat_cyc1", 32'(m_valid), 32'd0);
      tick();
      check("lat_cyc2", 32'(m_valid), 32'd0);
      tick();
      check("lat_cyc3", 32'(m_valid), 32'd1);
      check("lat_data", 32'(m_data), 32'hA1);
      check("lat_count", 32'(count), 32'd1);
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      check("lat_empty", 32'(empty), 32'd1);

      // Fill: 258 pushes with no pops.
      for (int i = 0; i < 258; i++) begin
         s_valid = 1'b1;
         s_data  = 8'(i);
         check("fill_s_ready", 32'(s_ready), 32'd1);
         tick();
      end
      check("full_flag", 32'(full), 32'd1);
      check("full_count", 32'(count), 32'd258);
      check("full_s_ready", 32'(s_ready), 32'd0);
      s_data = 8'hEE;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("full_hold_s_ready", 32'(s_ready), 32'd0);
         check("full_hold_count", 32'(count), 32'd258);
      end

      // Push and pop while full: only the pop succeeds until space frees.
      s_data  = 8'h77;
      m_ready = 1'b1;
      #1;
      check("fullpop_s_ready", 32'(s_ready), 32'd0);
      tick();
      check("fullpop_ready_back", 32'(s_ready), 32'd1);
      tick();
      s_valid = 1'b0;
      drain(600);

      // Streaming 600 cycles; no bubbles once the buffer is primed.
      m_ready   = 1'b1;
      bubbles   = 0;
      seen      = 0;
      pop_start = pop_cnt;
      for (int c = 0; c < 600; c++) begin
         s_valid = 1'b1;
         s_data  = 8'(c);
         if (seen != 0 && !m_valid) bubbles++;
         if (m_valid) seen = 1;
         tick();
      end
      s_valid = 1'b0;
      check("stream_bubbles", 32'(bubbles), 32'd0);
      check("stream_pops", 32'(pop_cnt - pop_start), 32'd597);
      drain(20);

      // Reset mid-burst with five words stored.
      for (int i = 0; i < 5; i++) begin
         s_valid = 1'b1;
         s_data  = 8'(8'h10 + i);
         tick();
      end
      s_valid = 1'b0;
      tick();
      tick();
      check("pre_rst_count", 32'(count), 32'd5);
      rst = 1'b1;
      #1;
      check("async_m_valid", 32'(m_valid), 32'd0);
      check("async_count", 32'(count), 32'd0);
      check("async_empty", 32'(empty), 32'd1);
      check("async_s_ready", 32'(s_ready), 32'd0);
      tick();
      tick();
      rst = 1'b0;
      s_valid = 1'b1;
      s_data  = 8'h3C;
      tick();
      s_valid = 1'b0;
      wait_valid(10);
      check("post_rst_data", 32'(m_data), 32'h3C);
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      check("post_rst_empty", 32'(empty), 32'd1);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
